// File: rtl/instruction_fetch_pkg.sv
// Shared MIPS fetch-stage definitions: NOP/HALT encodings, opcode field, fetch-path select.
package instruction_fetch_pkg;

    localparam int unsigned NB_DATA_DEF = 32;
    localparam int unsigned OPCODE_MSB  = 31;
    localparam int unsigned OPCODE_LSB  = 26;

    localparam logic [31:0] NOP_INSTR   = 32'h0000_0000;
    localparam logic [5:0]  HALT_OPCODE = 6'b111111;

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_JUMP,
        SEL_SEQ
    } fetch_sel_e;

    function automatic logic is_halt(input logic [31:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/instruction_memory.sv
// Byte-addressed instruction store: big-endian word write port, asynchronous word read.
module instruction_memory #(
    parameter int unsigned NB_DATA = 32,
    parameter int unsigned NB_ADDR = 10
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic [NB_ADDR-1:0] i_raddr,
    output logic [NB_DATA-1:0] o_rdata
);

    logic [7:0] mem [2**NB_ADDR];

    logic [NB_ADDR-3:0] wword;
    logic [NB_ADDR-3:0] rword;

    assign wword = i_waddr[NB_ADDR-1:2];
    assign rword = i_raddr[NB_ADDR-1:2];

    // Contents are deliberately not reset so a loaded program survives i_rst.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[{wword, 2'd0}] <= i_wdata[NB_DATA-1 -: 8];
            mem[{wword, 2'd1}] <= i_wdata[NB_DATA-9 -: 8];
            mem[{wword, 2'd2}] <= i_wdata[NB_DATA-17 -: 8];
            mem[{wword, 2'd3}] <= i_wdata[NB_DATA-25 -: 8];
        end
    end

    assign o_rdata = {mem[{rword, 2'd0}], mem[{rword, 2'd1}],
                      mem[{rword, 2'd2}], mem[{rword, 2'd3}]};

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, next-PC selection, IF/ID register and HALT latch over instruction_memory.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int unsigned        NB_DATA  = NB_DATA_DEF,
    parameter int unsigned        NB_ADDR  = 10,
    parameter logic [NB_DATA-1:0] PC_RESET = '0
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_enable,
    input  logic               i_stall,
    input  logic               i_jump,
    input  logic [NB_DATA-1:0] i_addr2jump,
    input  logic               i_inst_we,
    input  logic [NB_ADDR-1:0] i_inst_addr,
    input  logic [NB_DATA-1:0] i_inst_data,
    output logic [NB_DATA-1:0] o_instruction,
    output logic [NB_DATA-1:0] o_pcounter4,
    output logic [NB_DATA-1:0] o_pc,
    output logic               o_halt
);

    logic [NB_DATA-1:0] pc;
    logic [NB_DATA-1:0] pc_plus4;
    logic [NB_DATA-1:0] jump_target;
    logic [NB_DATA-1:0] fetched;
    logic               adv;
    fetch_sel_e         sel;

    instruction_memory #(
        .NB_DATA (NB_DATA),
        .NB_ADDR (NB_ADDR)
    ) u_imem (
        .clk     (clk),
        .i_we    (i_inst_we & ~i_enable),
        .i_waddr (i_inst_addr),
        .i_wdata (i_inst_data),
        .i_raddr (pc[NB_ADDR-1:0]),
        .o_rdata (fetched)
    );

    assign adv         = i_enable & ~i_stall & ~o_halt;
    assign pc_plus4    = pc + NB_DATA'(4);
    assign jump_target = {i_addr2jump[NB_DATA-1:2], 2'b00};
    assign o_pc        = pc;

    // A stalled or halted stage swallows i_jump; ID re-asserts it once unstalled.
    always_comb begin
        sel = SEL_HOLD;
        if (adv) begin
            sel = i_jump ? SEL_JUMP : SEL_SEQ;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            pc            <= PC_RESET;
            o_instruction <= NOP_INSTR;
            o_pcounter4   <= '0;
            o_halt        <= 1'b0;
        end else begin
            case (sel)
                SEL_JUMP: begin
                    pc            <= jump_target;
                    o_instruction <= NOP_INSTR;
                    o_pcounter4   <= jump_target;
                end
                SEL_SEQ: begin
                    pc            <= pc_plus4;
                    o_instruction <= fetched;
                    o_pcounter4   <= pc_plus4;
                    if (is_halt(fetched)) begin
                        o_halt <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed + randomized bench for instruction_fetch against a word-level behavioural model.
module tb_instruction_fetch;

    localparam int NB_DATA = 32;
    localparam int NB_ADDR = 10;

    logic               clk = 1'b0;
    logic               i_rst, i_enable, i_stall, i_jump, i_inst_we;
    logic [NB_DATA-1:0] i_addr2jump, i_inst_data;
    logic [NB_ADDR-1:0] i_inst_addr;
    logic [NB_DATA-1:0] o_instruction, o_pcounter4, o_pc;
    logic               o_halt;

    always #5 clk = ~clk;

    instruction_fetch #(
        .NB_DATA  (NB_DATA),
        .NB_ADDR  (NB_ADDR),
        .PC_RESET (32'h0)
    ) dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_enable      (i_enable),
        .i_stall       (i_stall),
        .i_jump        (i_jump),
        .i_addr2jump   (i_addr2jump),
        .i_inst_we     (i_inst_we),
        .i_inst_addr   (i_inst_addr),
        .i_inst_data   (i_inst_data),
        .o_instruction (o_instruction),
        .o_pcounter4   (o_pcounter4),
        .o_pc          (o_pc),
        .o_halt        (o_halt)
    );

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    // Reference: program memory as 256 words, stage as four plain values.
    logic [31:0] mm [256];
    logic [31:0] m_pc, m_inst, m_pc4;
    logic        m_halt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input logic rst, input logic en, input logic stall, input logic jump,
                       input logic [31:0] tgt, input logic we, input logic [9:0] addr,
                       input logic [31:0] data);
        i_rst = rst; i_enable = en; i_stall = stall; i_jump = jump;
        i_addr2jump = tgt; i_inst_we = we; i_inst_addr = addr; i_inst_data = data;
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_inst = 32'h0; m_pc4 = 32'h0; m_halt = 1'b0;
        end else if (en && !stall && !m_halt) begin
            if (jump) begin
                m_pc   = tgt & ~32'h3;
                m_inst = 32'h0;
                m_pc4  = m_pc;
            end else begin
                m_inst = mm[m_pc[9:2]];
                m_pc4  = m_pc + 32'd4;
                m_pc   = m_pc4;
                if (m_inst[31:26] == 6'h3f) m_halt = 1'b1;
            end
        end
        if (we && !en) mm[addr[9:2]] = data;
        #1;
        check("pc", o_pc, m_pc);
        check("instr", o_instruction, m_inst);
        check("pc4", o_pcounter4, m_pc4);
        check("halt", {31'b0, o_halt}, {31'b0, m_halt});
    endtask

    task automatic reset1();
        cyc(1, 0, 0, 0, 32'h0, 0, 10'h0, 32'h0);
    endtask
    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc(0, 1, 0, 0, 32'h0, 0, 10'h0, 32'h0);
    endtask
    task automatic load(input logic [9:0] a, input logic [31:0] d);
        cyc(0, 0, 0, 0, 32'h0, 1, a, d);
    endtask
    task automatic jump_to(input logic [31:0] t);
        cyc(0, 1, 0, 1, t, 0, 10'h0, 32'h0);
    endtask

    function automatic logic [31:0] nonhalt_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == 6'h3f) w[31:26] = 6'h08;
        return w;
    endfunction

    logic [31:0] old3fc;

    initial begin
        reset1();
        check("reset_instr", o_instruction, 32'h0);
        check("reset_pc", o_pc, 32'h0);
        for (int w = 0; w < 256; w++) load(10'(w * 4), nonhalt_word());

        // Program with HALT at 0x08
        load(10'h000, 32'h2001_0005);
        load(10'h004, 32'h2002_0007);
        load(10'h008, 32'hFC00_0000);
        reset1();
        run(1); check("t1_c1", o_instruction, 32'h2001_0005);
        run(1); check("t1_c2", o_instruction, 32'h2002_0007);
        run(1); check("t1_c3", o_instruction, 32'hFC00_0000);
        check("t1_halt", {31'b0, o_halt}, 32'h1);
        check("t1_pc4", o_pcounter4, 32'd12);
        run(2); check("t1_pc_hold", o_pc, 32'd12);
        jump_to(32'h80); check("halt_ignores_jump", o_pc, 32'd12);

        // Reset while halted: memory survives
        cyc(1, 1, 0, 0, 32'h0, 0, 10'h0, 32'h0);
        check("t6_halt", {31'b0, o_halt}, 32'h0);
        run(1); check("t6_refetch", o_instruction, 32'h2001_0005);

        // Stall at PC=8, then jump from 0x10
        reset1();
        load(10'h008, nonhalt_word());
        reset1();
        run(2);
        cyc(0, 1, 1, 0, 32'h0, 0, 10'h0, 32'h0);
        cyc(0, 1, 1, 0, 32'h0, 0, 10'h0, 32'h0);
        check("t2_hold_pc", o_pc, 32'h8);
        run(2);
        check("t3_pc_before", o_pc, 32'h10);
        jump_to(32'h42);
        check("t3_pc4", o_pcounter4, 32'h40);
        check("t3_squash", o_instruction, 32'h0);
        run(1);

        // Stall beats jump; jump alone redirects
        cyc(0, 1, 1, 1, 32'h80, 0, 10'h0, 32'h0);
        cyc(0, 1, 0, 1, 32'h80, 0, 10'h0, 32'h0);
        check("t4_redirect", o_pc, 32'h80);

        // Loader gating and PC wrap
        old3fc = mm[255];
        cyc(0, 1, 0, 0, 32'h0, 1, 10'h3FC, 32'hDEAD_BEEF);
        jump_to(32'h3FC); run(1);
        check("t5_dropped", o_instruction, old3fc);
        reset1();
        load(10'h3FC, 32'hDEAD_BEEF);
        jump_to(32'h3FC); run(1);
        check("t5_written", o_instruction, 32'hDEAD_BEEF);
        check("t5_pc_wrap", o_pc, 32'h400);
        run(1);

        // Randomized traffic
        reset1();
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
                ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 10),
                $urandom, ($urandom_range(0, 99) < 25), 10'($urandom), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
